// File: rtl/axi_uart_pkg.sv
// Shared definitions for the UART receive path: deframer FSM states, the
// default sync byte and the 9-bit character layout produced by axi_uart_rx.
package axi_uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Character layout: byte in [8:1], parity-error flag in [0].
  localparam int CH_W        = 9;
  localparam int CH_FLAG_BIT = 0;
  localparam int CH_BYTE_LSB = 1;
  localparam int CH_BYTE_MSB = 8;

endpackage

// File: rtl/axi_uart_frame_buf.sv
// Single-frame payload store: synchronous write, asynchronous read.
// The deframer owns both pointers.
module axi_uart_frame_buf #(
  parameter int MAX_LEN = 64,
  parameter int PW      = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [PW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_LEN];

  // Payload write; contents need no reset since only validated frames are read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_uart_deframer.sv
// Frame hunter/validator behind axi_uart_rx. Frames are SYNC, LEN, payload,
// CHK (XOR of LEN and payload); only fully checked frames are replayed.
// Optional inter-byte watchdog: define AXI_UART_DEFRAMER_TIMEOUT_EN.
module axi_uart_deframer
  import axi_uart_pkg::*;
#(
  parameter int         MAX_LEN = 64,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_W-1:0] i_tdata,
  input  logic            i_tvalid,
  output logic            i_tready,
  output logic [7:0]      o_tdata,
  output logic            o_tvalid,
  output logic            o_tlast,
  input  logic            o_tready,
  output logic            frame_ok,
  output logic            err_chk,
  output logic            err_len,
  output logic            err_parity,
  output logic            err_timeout
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d, sum_q, sum_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          started_q;
  logic          ok_d, echk_d, elen_d, epar_d;
  logic          ok_q, echk_q, elen_q, epar_q;
  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic [7:0]    rx_byte;
  logic          rx_par, accept, in_frame, len_bad, last_wr, last_rd, to_hit;

  assign rx_byte  = i_tdata[CH_BYTE_MSB:CH_BYTE_LSB];
  assign rx_par   = i_tdata[CH_FLAG_BIT];
  assign accept   = i_tvalid & i_tready;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign len_bad  = (rx_byte == 8'd0) || ({24'd0, rx_byte} > 32'(MAX_LEN));
  assign last_wr  = (8'(wr_q) == (len_q - 8'd1));
  assign last_rd  = (8'(rd_q) == (len_q - 8'd1));

`ifdef AXI_UART_DEFRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
  logic          eto_q;

  // Idle counter only runs while waiting inside a frame; any accepted byte
  // or state change (which always coincides with a byte or a timeout) clears it.
  assign to_hit = in_frame && !accept && (to_q == TW'(TIMEOUT - 1));

  // Next idle count.
  always_comb begin
    to_d = '0;
    if (in_frame && !accept && !to_hit) to_d = to_q + 1'b1;
  end

  // Idle counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q  <= '0;
      eto_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      eto_q <= to_hit;
    end
  end

  assign err_timeout = eto_q;
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Next-state, datapath updates and error classification.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    buf_we  = 1'b0;
    ok_d    = 1'b0;
    echk_d  = 1'b0;
    elen_d  = 1'b0;
    epar_d  = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (accept && rx_byte == SYNC) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (accept) begin
          if (rx_par) begin
            epar_d  = 1'b1;
            state_d = ST_HUNT;
          end else if (len_bad) begin
            elen_d  = 1'b1;
            state_d = ST_HUNT;
          end else begin
            len_d   = rx_byte;
            sum_d   = rx_byte;
            wr_d    = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          if (rx_par) begin
            epar_d  = 1'b1;
            state_d = ST_HUNT;
          end else begin
            buf_we = 1'b1;
            sum_d  = sum_q ^ rx_byte;
            wr_d   = wr_q + 1'b1;
            if (last_wr) state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (rx_par) begin
            epar_d  = 1'b1;
            state_d = ST_HUNT;
          end else if (rx_byte == sum_q) begin
            ok_d    = 1'b1;
            rd_d    = '0;
            state_d = ST_DRAIN;
          end else begin
            echk_d  = 1'b1;
            state_d = ST_HUNT;
          end
        end
      end
      ST_DRAIN: begin
        if (o_tready) begin
          rd_d = rd_q + 1'b1;
          if (last_rd) state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase
    if (to_hit) state_d = ST_HUNT;
  end

  // State, pointers, checksum and registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      len_q     <= '0;
      sum_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      started_q <= 1'b0;
      ok_q      <= 1'b0;
      echk_q    <= 1'b0;
      elen_q    <= 1'b0;
      epar_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      started_q <= 1'b1;
      ok_q      <= ok_d;
      echk_q    <= echk_d;
      elen_q    <= elen_d;
      epar_q    <= epar_d;
    end
  end

  axi_uart_frame_buf #(.MAX_LEN(MAX_LEN), .PW(PW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_q),
    .wdata (rx_byte),
    .raddr (rd_q),
    .rdata (buf_rdata)
  );

  // started_q holds i_tready low until the first edge after reset release.
  assign i_tready   = started_q && (state_q != ST_DRAIN);
  assign o_tvalid   = (state_q == ST_DRAIN);
  assign o_tdata    = o_tvalid ? buf_rdata : 8'h00;
  assign o_tlast    = o_tvalid && last_rd;
  assign frame_ok   = ok_q;
  assign err_chk    = echk_q;
  assign err_len    = elen_q;
  assign err_parity = epar_q;

endmodule
